// File: rtl/mem_access_unit.sv
// mem_access_unit -- MEM-stage data-memory access unit.
//
// Takes the EX/MEM register outputs, runs byte/half/word loads and stores
// over a req/ack data-memory handshake and loads the MEM/WB register.
// While an access is outstanding Stall holds EX/MEM and everything upstream.
//
// Ports
//   Clk, Clr_n            clock, synchronous active-low reset
//   MEM_*                 EX/MEM register outputs (control, address, store data)
//   DM_Req/We/Addr/...    registered data-memory request, held stable in REQ
//   DM_Ack, DM_RdData     memory completion and read data
//   Stall                 combinational upstream hold
//   WB_*                  MEM/WB register outputs
//   Misaligned            one-cycle trap pulse (only with MEM_MISALIGN_TRAP_EN)
//
// Configuration macro: MEM_MISALIGN_TRAP_EN -- when defined, misaligned
// half/word accesses trap instead of being aligned down.
module mem_access_unit (
  input  logic        Clk,
  input  logic        Clr_n,
  input  logic        MEM_MemRead,
  input  logic        MEM_MemWrite,
  input  logic [1:0]  MEM_Datatype,
  input  logic [31:0] MEM_ALUResult,
  input  logic [31:0] MEM_Data2,
  input  logic        MEM_RegWrite,
  input  logic        MEM_MemtoReg,
  input  logic [4:0]  MEM_RegDstData,
  output logic        DM_Req,
  output logic        DM_We,
  output logic [31:0] DM_Addr,
  output logic [31:0] DM_WrData,
  output logic [3:0]  DM_ByteEn,
  input  logic        DM_Ack,
  input  logic [31:0] DM_RdData,
`ifdef MEM_MISALIGN_TRAP_EN
  output logic        Misaligned,
`endif
  output logic        Stall,
  output logic        WB_RegWrite,
  output logic        WB_MemtoReg,
  output logic [4:0]  WB_RegDstData,
  output logic [31:0] WB_ReadData,
  output logic [31:0] WB_ALUResult
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2} state_t;

  localparam logic [1:0] DT_WORD = 2'b00;
  localparam logic [1:0] DT_HALF = 2'b01;
  localparam logic [1:0] DT_BYTE = 2'b10;

  state_t      state;
  logic [31:0] rd_buf;
  logic        access;
  logic        mis;
  logic        go;
  logic [1:0]  a;
  logic [31:0] wdata;
  logic [3:0]  ben;
  logic [31:0] ext;

  assign access = MEM_MemRead | MEM_MemWrite;
  assign a      = MEM_ALUResult[1:0];

`ifdef MEM_MISALIGN_TRAP_EN
  assign mis = access & (((MEM_Datatype == DT_HALF) & a[0]) |
                         ((MEM_Datatype == DT_WORD) & (a != 2'b00)));
`else
  assign mis = 1'b0;
`endif

  assign go    = access & ~mis;
  assign Stall = Clr_n & (((state == IDLE) & go) | (state == REQ));

  // Store lane steering; unused low address bits are simply ignored, which
  // gives the align-down behaviour when the trap is not built in.
  always_comb begin
    wdata = MEM_Data2;
    ben   = 4'b1111;
    case (MEM_Datatype)
      DT_WORD: begin
        wdata = MEM_Data2;
        ben   = 4'b1111;
      end
      DT_HALF: begin
        wdata = {2{MEM_Data2[15:0]}};
        ben   = a[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        wdata = {4{MEM_Data2[7:0]}};
        ben   = 4'b0001 << a;
      end
    endcase
  end

  // Load extraction from the buffered read data; EX/MEM is still holding
  // the same instruction in DONE, so the address bits are still valid.
  always_comb begin
    ext = rd_buf;
    case (MEM_Datatype)
      DT_WORD: ext = rd_buf;
      DT_HALF: ext = a[1] ? {{16{rd_buf[31]}}, rd_buf[31:16]}
                          : {{16{rd_buf[15]}}, rd_buf[15:0]};
      DT_BYTE: begin
        case (a)
          2'd0:    ext = {{24{rd_buf[7]}},  rd_buf[7:0]};
          2'd1:    ext = {{24{rd_buf[15]}}, rd_buf[15:8]};
          2'd2:    ext = {{24{rd_buf[23]}}, rd_buf[23:16]};
          default: ext = {{24{rd_buf[31]}}, rd_buf[31:24]};
        endcase
      end
      default: begin
        case (a)
          2'd0:    ext = {24'd0, rd_buf[7:0]};
          2'd1:    ext = {24'd0, rd_buf[15:8]};
          2'd2:    ext = {24'd0, rd_buf[23:16]};
          default: ext = {24'd0, rd_buf[31:24]};
        endcase
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Clr_n) begin
      state         <= IDLE;
      rd_buf        <= '0;
      DM_Req        <= 1'b0;
      DM_We         <= 1'b0;
      DM_Addr       <= '0;
      DM_WrData     <= '0;
      DM_ByteEn     <= '0;
      WB_RegWrite   <= 1'b0;
      WB_MemtoReg   <= 1'b0;
      WB_RegDstData <= '0;
      WB_ReadData   <= '0;
      WB_ALUResult  <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
      Misaligned    <= 1'b0;
`endif
    end else begin
`ifdef MEM_MISALIGN_TRAP_EN
      Misaligned    <= 1'b0;
`endif
      // Address and rd always follow EX/MEM; only control and data differ
      // between pass-through, bubble and load completion.
      WB_RegDstData <= MEM_RegDstData;
      WB_ALUResult  <= MEM_ALUResult;
      case (state)
        IDLE: begin
          if (go) begin
            state       <= REQ;
            DM_Req      <= 1'b1;
            DM_We       <= MEM_MemWrite;   // write wins on read+write
            DM_Addr     <= {MEM_ALUResult[31:2], 2'b00};
            DM_WrData   <= wdata;
            DM_ByteEn   <= MEM_MemWrite ? ben : 4'b1111;
            WB_RegWrite <= 1'b0;
            WB_MemtoReg <= 1'b0;
            WB_ReadData <= '0;
          end else if (mis) begin
`ifdef MEM_MISALIGN_TRAP_EN
            Misaligned  <= 1'b1;
`endif
            WB_RegWrite <= 1'b0;
            WB_MemtoReg <= 1'b0;
            WB_ReadData <= '0;
          end else begin
            WB_RegWrite <= MEM_RegWrite;
            WB_MemtoReg <= MEM_MemtoReg;
            WB_ReadData <= '0;
          end
        end
        REQ: begin
          WB_RegWrite <= 1'b0;
          WB_MemtoReg <= 1'b0;
          WB_ReadData <= '0;
          if (DM_Ack) begin
            rd_buf <= DM_RdData;
            DM_Req <= 1'b0;
            state  <= DONE;
          end
        end
        DONE: begin
          // The single WB write for this memory instruction.
          WB_RegWrite <= MEM_RegWrite;
          WB_MemtoReg <= MEM_MemtoReg;
          WB_ReadData <= ext;
          state       <= IDLE;
        end
        default: begin
          state       <= IDLE;
          DM_Req      <= 1'b0;
          WB_RegWrite <= 1'b0;
          WB_MemtoReg <= 1'b0;
          WB_ReadData <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

MEM-stage data-memory access unit. Consumes the EX/MEM pipeline register outputs, performs byte/half/word loads and stores over a req/ack data-memory handshake, and produces the MEM/WB register contents. While an access is outstanding it asserts `Stall`, which holds the EX/MEM register and everything upstream.

## Interface
- No parameters; data width is fixed at 32 bits and register index width at 5 bits.

Ports:
- `Clk` in 1 — clock; all state changes on the rising edge.
- `Clr_n` in 1 — reset, synchronous, active-low.
- `MEM_MemRead` in 1 — load request.
- `MEM_MemWrite` in 1 — store request.
- `MEM_Datatype` in 2 — access size:
  - 00: word.
  - 01: halfword, signed.
  - 10: byte, signed.
  - 11: byte, unsigned.
- `MEM_ALUResult` in 32 — effective address, and the ALU result passed to WB.
- `MEM_Data2` in 32 — store data.
- `MEM_RegWrite` in 1 — pipeline control, passed to WB.
- `MEM_MemtoReg` in 1 — pipeline control, passed to WB.
- `MEM_RegDstData` in 5 — destination register, passed to WB.
- `DM_Req` out 1 — memory request; registered.
- `DM_We` out 1 — 1 = write.
- `DM_Addr` out 32 — word-aligned address, `{addr[31:2],2'b00}`.
- `DM_WrData` out 32 — lane-replicated store data.
- `DM_ByteEn` out 4 — byte enables, little-endian.
- `DM_Ack` in 1 — memory completion.
- `DM_RdData` in 32 — read data; valid when `DM_Ack`=1.
- `Stall` out 1 — combinational; holds upstream pipeline registers.
- `WB_RegWrite`, `WB_MemtoReg` out 1 — MEM/WB register outputs.
- `WB_RegDstData` out 5 — MEM/WB register output.
- `WB_ReadData`, `WB_ALUResult` out 32 — MEM/WB register outputs.
- `Misaligned` out 1 — one-cycle trap pulse; present only with `MEM_MISALIGN_TRAP_EN`.

## Operation
- **Access detection.** `access = MEM_MemRead | MEM_MemWrite`.
  - Both bits set: a store is performed and the read is ignored.
- **FSM states and transitions:**
  - IDLE: if `access` → REQ; otherwise stay in IDLE.
  - REQ: `DM_Req`=1, `DM_Addr`/`DM_We`/`DM_WrData`/`DM_ByteEn` held stable. If `DM_Ack` → capture `DM_RdData` and go to DONE; otherwise stay in REQ.
  - DONE: go to IDLE unconditionally. The `access` check is not applied in DONE.
- **Stall.** `Stall = Clr_n & ((IDLE & access) | REQ)`. Stall is 0 in DONE, so EX/MEM advances at the end of DONE.
- **MEM/WB load rules:**
  - IDLE with no access: pass-through of the inputs; `WB_ReadData` = 0.
  - IDLE with access, and REQ: load a bubble (`WB_RegWrite`=0, `WB_MemtoReg`=0).
  - DONE: load the inputs plus the extended read data. Each instruction writes WB exactly once.
- **Store lane steering** (a = `addr[1:0]`):
  - Byte: `DM_WrData = {4{Data2[7:0]}}`, `DM_ByteEn = 1<<a`.
  - Half: `DM_WrData = {2{Data2[15:0]}}`, `DM_ByteEn` = 1100 if a[1], else 0011.
  - Word: `DM_WrData = Data2`, `DM_ByteEn` = 1111.
  - Loads drive `DM_ByteEn` = 1111.
- **Load extraction:**
  - Select the lane by a.
  - Datatype 01 and 10: sign-extend. Datatype 11: zero-extend.
  - Word: no change.

## Timing
- Reset: every registered output is 0 (`DM_Req`, `DM_We`, `DM_Addr`, `DM_WrData`, `DM_ByteEn`, all `WB_*`, `Misaligned`). State = IDLE and `Stall` = 0.
- Reset taken in REQ: `DM_Req` drops at that edge and the request is abandoned. The memory tolerates an abandoned request.
- Zero-wait memory (`DM_Ack` in the first REQ cycle):
  - Cycle 0: IDLE with access.
  - Cycle 1: REQ with ack.
  - Cycle 2: DONE; `WB_ReadData` valid from cycle 3.
  - 2 stall cycles in total.
- Each extra wait cycle adds one stall cycle.
- `DM_Ack` is ignored outside REQ.
- Non-memory instructions: 1-cycle pass-through, no stall.

## Configuration
- `MEM_MISALIGN_TRAP_EN` defined:
  - Misaligned cases: halfword with `addr[0]`=1; word with `addr[1:0]` ≠ 0.
  - A misaligned access in IDLE issues no request and does not stall.
  - `Misaligned` pulses high for the next cycle and MEM/WB loads a bubble.
- `MEM_MISALIGN_TRAP_EN` undefined:
  - Low address bits that are illegal for the access size are ignored (address aligned down); the access proceeds normally.
  - `Misaligned` port absent.

## Test plan
- Signed byte load: lb, Datatype 10, addr 0x1003, `DM_RdData` 0x80123456, ack immediate → `DM_ByteEn` 1111, `DM_Addr` 0x1000, `WB_ReadData` 0xFFFFFF80, `Stall` high exactly 2 cycles.
- Halfword store: sh, addr 0x2002, Data2 0x0000BEEF → `DM_WrData` 0xBEEFBEEF, `DM_ByteEn` 1100, `DM_We`=1, `WB_RegWrite` follows the input in DONE.
- Waited word load: lw, Datatype 00, ack delayed 3 cycles after REQ entry → `Stall` high 5 cycles, `DM_Req` stable throughout, `WB_ReadData` = `DM_RdData` sampled at ack, one WB write.
- Unsigned byte and read+write conflict:
  - lbu at addr 0x0001, RdData 0x0000F000 → `WB_ReadData` 0x000000F0.
  - Read+write both set → `DM_We`=1.
- Reset and pass-through:
  - `Clr_n` low during REQ → next cycle `DM_Req`=0, `Stall`=0, all WB outputs 0.
  - Then an ALU instruction (RegWrite=1, rd=5, ALUResult 0x1234) → `WB_*` reflect it after 1 cycle, no stall.
- Misaligned word load: lw at 0x1001 with `MEM_MISALIGN_TRAP_EN` → `Misaligned` 1-cycle pulse, no `DM_Req`, WB bubble. Without the macro → `DM_Addr` 0x1000 and a normal access.
